// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - frame output handshake bundle for seg7_scan_decoder
interface seg7_scan_decoder_if #(
  parameter int NDIG = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_bcd;
  logic [NDIG-1:0]   out_err;

  modport master (output out_valid, output out_bcd, output out_err, input out_ready);
  modport slave  (input out_valid, input out_bcd, input out_err, output out_ready);
endinterface

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers BCD frames from a multiplexed active-low 7-segment bus
// Optional feature: define SEG7_BLANK_EN to decode the all-off pattern as blank (4'hF).
module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NDIG-1:0]         dig_en,
  seg7_scan_decoder_if.master     frm
);
  localparam int CW = $clog2(STABLE_CYC + 1);

  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t            state, state_nx;
  logic [6:0]        s_seg;
  logic [NDIG-1:0]   s_dig;
  logic [CW-1:0]     stab_cnt;
  logic [NDIG-1:0]   mask, mask_nx;
  logic [4*NDIG-1:0] bcd_q;
  logic [NDIG-1:0]   err_q;
  logic              same;
  logic              capture;
  logic [3:0]        dec_nib;
  logic              dec_err;

  assign same = (seg == s_seg) && (dig_en == s_dig);
  // Fires only on the transition into saturation, so a long stable run captures once.
  assign capture = same && (stab_cnt == CW'(STABLE_CYC - 1)) && $onehot(s_dig);

  always_comb begin
    dec_nib = 4'hE;
    dec_err = 1'b1;
    case (s_seg)
      7'b0000001: begin dec_nib = 4'd0; dec_err = 1'b0; end
      7'b1001111: begin dec_nib = 4'd1; dec_err = 1'b0; end
      7'b0010010: begin dec_nib = 4'd2; dec_err = 1'b0; end
      7'b0000110: begin dec_nib = 4'd3; dec_err = 1'b0; end
      7'b1001100: begin dec_nib = 4'd4; dec_err = 1'b0; end
      7'b0100100: begin dec_nib = 4'd5; dec_err = 1'b0; end
      7'b0100000: begin dec_nib = 4'd6; dec_err = 1'b0; end
      7'b0001111: begin dec_nib = 4'd7; dec_err = 1'b0; end
      7'b0000000: begin dec_nib = 4'd8; dec_err = 1'b0; end
      7'b0000100: begin dec_nib = 4'd9; dec_err = 1'b0; end
`ifdef SEG7_BLANK_EN
      7'b1111111: begin dec_nib = 4'hF; dec_err = 1'b0; end
`else
      7'b1111111: begin dec_nib = 4'hE; dec_err = 1'b1; end
`endif
      default:    begin dec_nib = 4'hE; dec_err = 1'b1; end
    endcase
  end

  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    case (state)
      COLLECT: begin
        if (capture) begin
          mask_nx = mask | s_dig;
          if (&mask_nx) state_nx = PRESENT;
        end
      end
      PRESENT: begin
        // Captures landing on the handshake edge are dropped; the digit waits for its next run.
        if (frm.out_ready) begin
          mask_nx  = '0;
          state_nx = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      s_seg    <= '0;
      s_dig    <= '0;
      stab_cnt <= '0;
      mask     <= '0;
      bcd_q    <= '0;
      err_q    <= '0;
    end else begin
      state <= state_nx;
      mask  <= mask_nx;
      s_seg <= seg;
      s_dig <= dig_en;
      if (!same) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CW'(STABLE_CYC)) begin
        stab_cnt <= stab_cnt + CW'(1);
      end
      if (state == COLLECT && capture) begin
        for (int i = 0; i < NDIG; i++) begin
          if (s_dig[i]) begin
            bcd_q[4*i +: 4] <= dec_nib;
            err_q[i]        <= dec_err;
          end
        end
      end
    end
  end

  assign frm.out_valid = (state == PRESENT);
  assign frm.out_bcd   = bcd_q;
  assign frm.out_err   = err_q;
endmodule
